// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B, LSB first, one bit per clock.
// Two half-subtractor stages form a full subtractor; the borrow is carried between bits in a flop.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] r_sh;
    logic [CW-1:0]    cnt;
    logic             br;

    logic             a_bit;
    logic             b_bit;
    logic             hs1_d;
    logic             hs1_b;
    logic             hs2_d;
    logic             hs2_b;
    logic             br_next;
    logic             last;
    logic [WIDTH-1:0] r_next;

    // r_sh keeps only the WIDTH-1 bits already produced; the current bit completes r_next.
    always_comb begin
        a_bit   = a_sh[0];
        b_bit   = b_sh[0];
        hs1_d   = a_bit ^ b_bit;
        hs1_b   = ~a_bit & b_bit;
        hs2_d   = hs1_d ^ br;
        hs2_b   = ~hs1_d & br;
        br_next = hs1_b | hs2_b;
        r_next  = {hs2_d, r_sh};
        last    = (cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start)     state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            r_sh      <= '0;
            cnt       <= '0;
            br        <= 1'b0;
            D         <= '0;
            Bo        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= A;
                        b_sh <= B;
                        br   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    r_sh <= r_next[WIDTH-1:1];
                    br   <= br_next;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        D         <= r_next;
                        Bo        <= br_next;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: constant vector table, hand-written corner sequences,
// and a negedge scoreboard that models every captured operation at WIDTH=8, plus a WIDTH=32 instance.
module tb_serial_subtractor;

    localparam int W  = 8;
    localparam int W2 = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start;
    logic          out_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  d;
    logic          bo;
    logic          busy;
    logic          out_valid;

    logic          start32;
    logic          ready32;
    logic [W2-1:0] a32;
    logic [W2-1:0] b32;
    logic [W2-1:0] d32;
    logic          bo32;
    logic          busy32;
    logic          valid32;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .busy(busy),
        .D(d), .Bo(bo), .out_valid(out_valid), .out_ready(out_ready)
    );

    serial_subtractor #(.WIDTH(W2)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .A(a32), .B(b32), .busy(busy32),
        .D(d32), .Bo(bo32), .out_valid(valid32), .out_ready(ready32)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        int           cap;
    } exp_t;
    exp_t sb[$];

    logic [W-1:0] pa, pb, pd;
    logic         pbusy = 1'b0, pvalid = 1'b0, pready = 1'b0, pbo = 1'b0;

    // Inputs only change 2 time units after a rising edge, so negedge samples are what the next edge sees.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (busy && !pbusy) begin
                e.d   = pa - pb;
                e.bo  = (pa < pb);
                e.cap = cyc;
                sb.push_back(e);
            end
            if (busy && !out_valid && pbusy && !pvalid) check("D_hold_run", d, pd);
            if (out_valid && pvalid) begin
                check("D_hold_done", d, pd);
                check("Bo_hold_done", bo, pbo);
            end
            if (pvalid && !pready) check("valid_held", out_valid, 1);
            if (pvalid && pready) begin
                check("valid_cleared", out_valid, 0);
                check("idle_after_accept", busy, 0);
            end
            if (out_valid && !pvalid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_empty: result appeared with no pending operation (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("sb_D", d, e.d);
                    check("sb_Bo", bo, e.bo);
                    check("latency", cyc - e.cap, W);
                end
            end
        end
        pa     = a;
        pb     = b;
        pd     = d;
        pbo    = bo;
        pbusy  = busy;
        pvalid = out_valid;
        pready = out_ready;
    end

    task automatic wait_valid(input string name);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 4 * W);
        if (!out_valid) check(name, 0, 1);
    endtask

    task automatic op8(input logic [W-1:0] av, input logic [W-1:0] bv, input int stall,
                       output logic [W-1:0] dv, output logic bov);
        @(posedge clk); #2;
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        a = W'($urandom);
        b = W'($urandom);
        wait_valid("valid_timeout");
        dv  = d;
        bov = bo;
        repeat (stall) @(posedge clk);
        @(posedge clk); #2;
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bo;
    } vec_t;

    initial begin
        vec_t         tbl[8];
        logic [W-1:0] dv, av, bv;
        logic         bov;
        int           lastc;
        int           t;
        logic [W2-1:0] ea, eb;

        tbl[0] = '{8'h35, 8'h12, 8'h23, 1'b0};
        tbl[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        tbl[2] = '{8'h80, 8'hFF, 8'h81, 1'b1};
        tbl[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        tbl[4] = '{8'h10, 8'h20, 8'hF0, 1'b1};
        tbl[5] = '{8'hAA, 8'h55, 8'h55, 1'b0};
        tbl[6] = '{8'h01, 8'h00, 8'h01, 1'b0};
        tbl[7] = '{8'h55, 8'hAA, 8'hAB, 1'b1};

        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        start32 = 1'b0; ready32 = 1'b0; a32 = '0; b32 = '0;

        repeat (5) begin
            @(posedge clk); #2;
            a = W'($urandom); b = W'($urandom);
            start = 1'($urandom); out_ready = 1'($urandom);
        end
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_D", d, 8'h00);
        check("rst_Bo", bo, 0);
        check("rst_valid32", valid32, 0);
        @(posedge clk); #2;
        start = 1'b0; out_ready = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            op8(tbl[i].a, tbl[i].b, i % 3, dv, bov);
            check("tbl_D", dv, tbl[i].d);
            check("tbl_Bo", bov, tbl[i].bo);
        end

        // Reset while bit 4 is about to be processed; D holds a nonzero previous result.
        @(posedge clk); #2;
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_D", d, 8'h00);
        check("midrst_Bo", bo, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        op8(8'h10, 8'h20, 0, dv, bov);
        check("postrst_D", dv, 8'hF0);
        check("postrst_Bo", bov, 1);

        // Consumer stall with start pulses that must be ignored.
        @(posedge clk); #2;
        a = 8'h9C; b = 8'h3E; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_valid("bp_valid_timeout");
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            start = i[0];
            a = W'($urandom);
        end
        @(posedge clk); #2;
        start = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_busy", busy, 0);
        check("bp_idle_valid", out_valid, 0);
        check("bp_D_kept", d, 8'h5E);
        #1 out_ready = 1'b0;

        // Back-to-back with start and out_ready held high; A changes mid-RUN.
        @(posedge clk); #2;
        a = 8'h40; b = 8'h03; start = 1'b1; out_ready = 1'b1;
        lastc = 0;
        for (int k = 0; k < 4; k++) begin
            wait_valid("b2b_valid_timeout");
            if (k > 0) check("b2b_period", cyc - lastc, W + 2);
            if (k == 2) check("b2b_D_old_a", d, 8'h3D);
            if (k == 3) check("b2b_D_new_a", d, 8'hC4);
            lastc = cyc;
            if (k == 1) begin
                repeat (4) @(posedge clk);
                #2 a = 8'hC7;
            end
        end
        @(posedge clk); #2;
        start = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < 4 * W);
        check("b2b_drain_idle", busy, 0);
        @(posedge clk); #2;
        out_ready = 1'b0;

        for (int i = 0; i < 300; i++) begin
            av = W'($urandom);
            bv = W'($urandom);
            op8(av, bv, $urandom_range(0, 2), dv, bov);
            check("rnd_D", dv, W'(av - bv));
            check("rnd_Bo", bov, av < bv);
        end

        for (int i = 0; i < 150; i++) begin
            ea = $urandom;
            eb = $urandom;
            if (i == 0) begin ea = '0; eb = '1; end
            if (i == 1) begin ea = '1; eb = '1; end
            @(posedge clk); #2;
            a32 = ea; b32 = eb; start32 = 1'b1;
            @(posedge clk); #2;
            start32 = 1'b0;
            lastc = cyc;
            a32 = $urandom;
            b32 = $urandom;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!valid32 && t < 4 * W2);
            check("w32_latency", cyc - lastc, W2);
            check("w32_D", d32, W2'(ea - eb));
            check("w32_Bo", bo32, ea < eb);
            @(posedge clk); #2;
            ready32 = 1'b1;
            @(posedge clk); #2;
            ready32 = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        n_vec++;
        n_err++;
        $display("FAIL watchdog: time limit reached at cycle %0d, required completion earlier", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
